// File: rtl/mbgd_apb_master.sv
// rtl/mbgd_apb_master.sv - command-queued APB master driving the MBGD_top register port
module mbgd_apb_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              apb_pclk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_paddress,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pready,
  output logic              busy,
  output logic [1:0]        state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // command storage: {write, addr, wdata}
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              timeout_hit, access_done;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  state_e            state_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !fifo_full;
  assign {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr_q];

  // The abort fires on the edge that would make the wait count reach TIMEOUT;
  // a late pready on that same edge still counts as a normal completion.
  assign timeout_hit = !apb_pready && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign access_done = (state_q == ST_ACCESS) && (apb_pready || timeout_hit);

  // FIFO push/pop decode; push is gated by full only, never by a same-edge pop
  always_comb begin
    push     = cmd_valid && !fifo_full;
    pop      = !fifo_empty && ((state_q == ST_IDLE) || access_done);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO pointers and occupancy
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO payload storage; contents are don't-care until written
  always_ff @(posedge apb_pclk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // APB transfer sequencer with registered bus and response outputs
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q   <= ST_SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= head_write;
            paddr_q   <= head_addr;
            pwdata_q  <= head_wdata;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
          tmo_q     <= '0;
        end
        ST_ACCESS: begin
          if (access_done) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= pwrite_q;
            rsp_err_q   <= !apb_pready;
            rsp_rdata_q <= (apb_pready && !pwrite_q) ? apb_prdata : '0;
            tmo_q       <= '0;
            penable_q   <= 1'b0;
            if (!fifo_empty) begin
              state_q  <= ST_SETUP;
              pwrite_q <= head_write;
              paddr_q  <= head_addr;
              pwdata_q <= head_wdata;
            end else begin
              state_q <= ST_IDLE;
              psel_q  <= 1'b0;
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign apb_psel     = psel_q;
  assign apb_penable  = penable_q;
  assign apb_pwrite   = pwrite_q;
  assign apb_paddress = paddr_q;
  assign apb_pwdata   = pwdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign state        = state_q;
  assign busy         = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mbgd_apb_master.sv
// tb/tb_mbgd_apb_master.sv - self-checking bench for mbgd_apb_master
module tb_mbgd_apb_master;

  logic       apb_pclk = 1'b0;
  logic       resetn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_write, rsp_err;
  logic [7:0] rsp_rdata;
  logic       apb_psel, apb_penable, apb_pwrite;
  logic [7:0] apb_paddress, apb_pwdata, apb_prdata;
  logic       apb_pready;
  logic       busy;
  logic [1:0] state;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       mon_e;
  logic [7:0] mon_rd;
  logic [7:0] smem    [0:255] = '{default: 8'h00};
  logic [7:0] ref_mem [0:255] = '{default: 8'h00};
  int         n_tests = 0;
  int         n_fail  = 0;
  int         rsp_seen = 0;

  mbgd_apb_master #(
    .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .apb_pclk    (apb_pclk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_paddress(apb_paddress),
    .apb_pwdata  (apb_pwdata),
    .apb_prdata  (apb_prdata),
    .apb_pready  (apb_pready),
    .busy        (busy),
    .state       (state)
  );

  always #5 apb_pclk = ~apb_pclk;

  assign apb_prdata = smem[apb_paddress];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave memory and in-order response scoreboard
  always @(negedge apb_pclk) begin
    if (resetn) begin
      if (apb_psel && apb_penable && apb_pready && apb_pwrite)
        smem[apb_paddress] = apb_pwdata;
      if (rsp_valid) begin
        rsp_seen++;
        check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          if (mon_e.e) begin
            mon_rd = 8'h00;
          end else if (mon_e.w) begin
            mon_rd = 8'h00;
            ref_mem[mon_e.a] = mon_e.d;
          end else begin
            mon_rd = ref_mem[mon_e.a];
          end
          check("rsp_write", 32'(rsp_write), 32'(mon_e.w));
          check("rsp_rdata", 32'(rsp_rdata), 32'(mon_rd));
          check("rsp_err",   32'(rsp_err),   32'(mon_e.e));
        end
      end
    end
  end

  task automatic step();
    @(posedge apb_pclk);
    #1;
  endtask

  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic e, output logic acc);
    exp_t ent;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    acc       = cmd_ready;
    if (acc) begin
      ent.w = w; ent.a = a; ent.d = d; ent.e = e;
      exp_q.push_back(ent);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       acc;
    logic [4:0] a_psel, a_pen, a_rv;
    int         n, seen0, issued, lowrun, cyc;
    exp_t       ent;

    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 8'h00; cmd_wdata = 8'h00; apb_pready = 1'b0;
    step(); step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_psel",      32'(apb_psel), 32'd0);
    check("rst_penable",   32'(apb_penable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_state",     32'(state), 32'd0);
    check("rst_paddr",     32'(apb_paddress), 32'd0);
    resetn = 1'b1;
    step();

    // two back-to-back writes, zero-wait slave
    apb_pready = 1'b1;
    a_psel = 5'b01111; a_pen = 5'b01010; a_rv = 5'b10100;
    send(1'b1, 8'h00, 8'hEE, 1'b0, acc);
    check("a_acc0", 32'(acc), 32'd1);
    send(1'b1, 8'h01, 8'hCC, 1'b0, acc);
    check("a_acc1", 32'(acc), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("a_psel",    32'(apb_psel),    32'(a_psel[k]));
      check("a_penable", 32'(apb_penable), 32'(a_pen[k]));
      check("a_rvalid",  32'(rsp_valid),   32'(a_rv[k]));
      if (k == 0) begin
        check("a_paddr0", 32'(apb_paddress), 32'h00);
        check("a_pwdata0", 32'(apb_pwdata), 32'hEE);
      end
      if (k == 2) begin
        check("a_paddr1", 32'(apb_paddress), 32'h01);
        check("a_pwdata1", 32'(apb_pwdata), 32'hCC);
      end
      step();
    end
    wait_idle();

    // read with three wait states
    apb_pready = 1'b0;
    send(1'b0, 8'h00, 8'h00, 1'b0, acc);
    step();
    check("b_setup", 32'(state), 32'd1);
    step();
    n = 0;
    while (state == 2'd2 && n < 64) begin
      n++;
      if (n == 4) apb_pready = 1'b1;
      step();
    end
    check("b_access_len", 32'(n), 32'd4);
    check("b_rsp_valid",  32'(rsp_valid), 32'd1);
    check("b_rsp_rdata",  32'(rsp_rdata), 32'hEE);
    check("b_rsp_write",  32'(rsp_write), 32'd0);
    wait_idle();

    // fill the queue behind a stalled transfer
    apb_pready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send((i % 2) == 0, 8'h10 + 8'(i / 2), 8'h30 + 8'(i), 1'b0, acc);
      check("c_cmd_ready", 32'(acc), 32'(i < 5));
    end
    check("c_busy", 32'(busy), 32'd1);
    seen0 = rsp_seen;
    apb_pready = 1'b1;
    wait_idle();
    check("c_rsp_count", 32'(rsp_seen - seen0), 32'd5);

    // timeout on a read, then a queued write completes
    apb_pready = 1'b0;
    send(1'b0, 8'h10, 8'h00, 1'b1, acc);
    send(1'b1, 8'h20, 8'h77, 1'b0, acc);
    step();
    n = 0;
    while (state == 2'd2 && n < 64) begin
      n++;
      step();
    end
    check("d_access_len", 32'(n), 32'd16);
    check("d_rsp_valid",  32'(rsp_valid), 32'd1);
    check("d_rsp_err",    32'(rsp_err), 32'd1);
    check("d_rsp_rdata",  32'(rsp_rdata), 32'h00);
    check("d_next_setup", 32'(state), 32'd1);
    apb_pready = 1'b1;
    step();
    step();
    check("d_w_valid", 32'(rsp_valid), 32'd1);
    check("d_w_err",   32'(rsp_err), 32'd0);
    check("d_w_write", 32'(rsp_write), 32'd1);
    wait_idle();

    // reset in the middle of an ACCESS with two commands queued
    apb_pready = 1'b0;
    send(1'b1, 8'h30, 8'h11, 1'b0, acc);
    send(1'b1, 8'h31, 8'h22, 1'b0, acc);
    send(1'b1, 8'h32, 8'h33, 1'b0, acc);
    check("e_in_access", 32'(state), 32'd2);
    seen0 = rsp_seen;
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("e_psel",    32'(apb_psel), 32'd0);
    check("e_penable", 32'(apb_penable), 32'd0);
    check("e_busy",    32'(busy), 32'd0);
    step(); step();
    resetn = 1'b1;
    apb_pready = 1'b1;
    repeat (10) step();
    check("e_cmd_ready", 32'(cmd_ready), 32'd1);
    check("e_state",     32'(state), 32'd0);
    check("e_no_rsp",    32'(rsp_seen - seen0), 32'd0);

    // randomized traffic against the in-order memory model
    issued = 0;
    lowrun = 0;
    cyc = 0;
    while (issued < 60 && cyc < 3000) begin
      if (lowrun >= 5 || $urandom_range(0, 2) != 0) begin
        apb_pready = 1'b1;
        lowrun = 0;
      end else begin
        apb_pready = 1'b0;
        lowrun++;
      end
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 8'($urandom_range(0, 7));
        cmd_wdata = 8'($urandom_range(0, 255));
        if (cmd_ready) begin
          ent.w = cmd_write; ent.a = cmd_addr; ent.d = cmd_wdata; ent.e = 1'b0;
          exp_q.push_back(ent);
          issued++;
        end
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      cyc++;
    end
    cmd_valid = 1'b0;
    apb_pready = 1'b1;
    wait_idle();
    check("r_issued",  32'(issued), 32'd60);
    check("r_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
